// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run/halt/step/dump sequencer: controller states,
// host command opcodes, halt cause codes and the EBREAK encoding.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DUMP = 2'd3
  } state_t;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_RUN   = 3'd1;
  localparam logic [2:0] CMD_HALT  = 3'd2;
  localparam logic [2:0] CMD_STEP  = 3'd3;
  localparam logic [2:0] CMD_DUMP  = 3'd4;
  localparam logic [2:0] CMD_SETBP = 3'd5;
  localparam logic [2:0] CMD_CLRBP = 3'd6;

  localparam logic [2:0] CAUSE_RESET  = 3'd0;
  localparam logic [2:0] CAUSE_HOST   = 3'd1;
  localparam logic [2:0] CAUSE_STEP   = 3'd2;
  localparam logic [2:0] CAUSE_BP     = 3'd3;
  localparam logic [2:0] CAUSE_EBREAK = 3'd4;

  localparam logic [31:0] EBREAK_INSN = 32'h00100073;

  // Highest register index streamed by a dump.
  localparam logic [4:0] LAST_REG = 5'd31;

  // Cause reported when a RUN-state halt condition fires; a breakpoint
  // outranks an EBREAK at the same PC.
  function automatic logic [2:0] stop_cause(input logic bp_hit);
    return bp_hit ? CAUSE_BP : CAUSE_EBREAK;
  endfunction

endpackage

// File: rtl/bp_match_unit.sv
// PC breakpoint slots: each slot holds a valid bit and a word address.
// hit is the OR of all valid slots whose address equals the current PC word.
module bp_match_unit #(
  parameter int BP_COUNT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_en,
  input  logic        clr_en,
  input  logic [1:0]  slot,
  input  logic [29:0] set_addr,
  input  logic [29:0] pc_word,
  output logic        hit
);

  logic [BP_COUNT-1:0]        slot_vld;
  logic [BP_COUNT-1:0][29:0]  slot_addr;

  // Slot update; a slot index beyond BP_COUNT-1 selects nothing and is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_vld  <= '0;
      slot_addr <= '0;
    end else begin
      for (int i = 0; i < BP_COUNT; i++) begin
        if (set_en && (slot == 2'(i))) begin
          slot_vld[i]  <= 1'b1;
          slot_addr[i] <= set_addr;
        end else if (clr_en && (slot == 2'(i))) begin
          slot_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Live match of every valid slot against the datapath PC.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < BP_COUNT; i++) begin
      hit = hit | (slot_vld[i] && (slot_addr[i] == pc_word));
    end
  end

endmodule

// File: rtl/run_controller.sv
// Run/halt/step/dump sequencer for the single-cycle RISC-V datapath.
// core_en gates PC, RegWrite and MemWrite; while it is low the architectural
// state is frozen. The core stops on host HALT, a PC breakpoint or EBREAK,
// and DUMP streams x0..x31 out through the datapath debug read port.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int BP_COUNT  = 2,
  parameter bit RESET_RUN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_data,
  input  logic [31:0] PC,
  input  logic [31:0] Instr,
  output logic        core_en,
  output logic [4:0]  dbg_sel,
  input  logic [31:0] dbg_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        halted,
  output logic [2:0]  halt_cause,
  output logic [31:0] retired
);

  state_t      state, state_nxt;
  logic        skip, skip_nxt;
  logic [2:0]  cause_nxt;
  logic [4:0]  sel_nxt;
  logic        cmd_acc;
  logic        bp_hit;
  logic        ebreak_hit;
  logic        halt_cond;
  logic        pc_unused;

  // PC byte-offset bits never take part in breakpoint matching.
  assign pc_unused = ^PC[1:0];

  // Host commands are only taken while the core is idle or free-running.
  assign cmd_ready = (state == ST_HALT) || (state == ST_RUN);
  assign cmd_acc   = cmd_valid && cmd_ready;

  bp_match_unit #(.BP_COUNT(BP_COUNT)) u_bp (
    .clk      (clk),
    .reset    (reset),
    .set_en   (cmd_acc && (cmd_op == CMD_SETBP)),
    .clr_en   (cmd_acc && (cmd_op == CMD_CLRBP)),
    .slot     (cmd_data[1:0]),
    .set_addr (cmd_data[31:2]),
    .pc_word  (PC[31:2]),
    .hit      (bp_hit)
  );

  assign ebreak_hit = (Instr == EBREAK_INSN);

  // skip masks the checks for the first RUN cycle so that resuming from a
  // breakpoint or EBREAK executes the stopping instruction once.
  assign halt_cond = (state == ST_RUN) && !skip && (bp_hit || ebreak_hit);

  // Next-state, commit enable and debug-select sequencing.
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip;
    cause_nxt = halt_cause;
    sel_nxt   = dbg_sel;
    core_en   = 1'b0;
    case (state)
      ST_HALT: begin
        if (cmd_acc) begin
          case (cmd_op)
            CMD_RUN: begin
              state_nxt = ST_RUN;
              skip_nxt  = 1'b1;
            end
            CMD_STEP: state_nxt = ST_STEP;
            CMD_DUMP: begin
              state_nxt = ST_DUMP;
              sel_nxt   = 5'd0;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        skip_nxt = 1'b0;
        if (halt_cond) begin
          // The stopping instruction does not commit, even with a host HALT pending.
          state_nxt = ST_HALT;
          cause_nxt = stop_cause(bp_hit);
        end else begin
          core_en = 1'b1;
          if (cmd_acc && (cmd_op == CMD_HALT)) begin
            state_nxt = ST_HALT;
            cause_nxt = CAUSE_HOST;
          end
        end
      end
      ST_STEP: begin
        core_en   = 1'b1;
        state_nxt = ST_HALT;
        cause_nxt = CAUSE_STEP;
      end
      ST_DUMP: begin
        if (dump_ready) begin
          if (dbg_sel == LAST_REG) begin
            state_nxt = ST_HALT;
            sel_nxt   = 5'd0;
          end else begin
            sel_nxt = dbg_sel + 5'd1;
          end
        end
      end
      default: state_nxt = ST_HALT;
    endcase
  end

  // Controller state; reset aborts any step or dump in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RESET_RUN ? ST_RUN : ST_HALT;
      skip       <= 1'b0;
      halt_cause <= CAUSE_RESET;
      dbg_sel    <= 5'd0;
    end else begin
      state      <= state_nxt;
      skip       <= skip_nxt;
      halt_cause <= cause_nxt;
      dbg_sel    <= sel_nxt;
    end
  end

  // Retired-cycle counter, free-wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired <= 32'd0;
    end else if (core_en) begin
      retired <= retired + 32'd1;
    end
  end

  assign halted     = (state == ST_HALT);
  assign dump_valid = (state == ST_DUMP);
  assign dump_idx   = dbg_sel;
  assign dump_data  = dbg_data;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: directed sequences, a breakpoint/
// EBREAK vector table and a randomized run against a rule-level model.
module tb_run_controller;

  localparam int          BPN    = 2;
  localparam logic [31:0] NOP_I  = 32'h00000013;
  localparam logic [31:0] EBRK   = 32'h00100073;
  localparam logic [2:0]  OP_NOP = 3'd0, OP_RUN = 3'd1, OP_HALT = 3'd2, OP_STEP = 3'd3;
  localparam logic [2:0]  OP_DUMP = 3'd4, OP_SETBP = 3'd5, OP_CLRBP = 3'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_data = 32'd0;
  logic [31:0] PC, Instr;
  logic        core_en;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_data;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        halted;
  logic [2:0]  halt_cause;
  logic [31:0] retired;

  // Tiny datapath stand-in: PC register advancing on core_en, a program that
  // is all NOPs except an optional EBREAK, and a register file behind dbg_sel.
  logic [31:0] pc_q;
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = 32'd0;
  logic        pc_force = 1'b0, instr_force = 1'b0;
  logic [31:0] pc_force_val = 32'd0, instr_force_val = 32'd0;
  logic        ebrk_en = 1'b0;
  logic [31:0] ebrk_addr = 32'd0;
  logic [31:0] regs [32];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  run_controller #(.BP_COUNT(BPN), .RESET_RUN(1'b0)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .PC(PC), .Instr(Instr),
    .core_en(core_en), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
    .dump_data(dump_data), .halted(halted), .halt_cause(halt_cause), .retired(retired)
  );

  assign PC       = pc_force ? pc_force_val : pc_q;
  assign Instr    = instr_force ? instr_force_val : ((ebrk_en && (PC == ebrk_addr)) ? EBRK : NOP_I);
  assign dbg_data = regs[dbg_sel];

  always @(posedge clk) begin
    if (pc_load) pc_q <= pc_load_val;
    else if (core_en) pc_q <= pc_q + 32'd4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    #1;
    chk("cmd_ready_on_issue", cmd_ready, 1);
    tick;
    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = 32'd0;
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_load = 1'b1; pc_load_val = v;
    tick;
    pc_load = 1'b0;
  endtask

  task automatic wait_halt(input int max_cyc);
    int n;
    n = 0;
    while (!halted && n < max_cyc) begin
      tick;
      n++;
    end
    chk("halt_within_bound", halted, 1);
  endtask

  task automatic do_reset;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = 32'd0;
    dump_ready = 1'b0; pc_force = 1'b0; instr_force = 1'b0; ebrk_en = 1'b0;
    pc_load = 1'b1; pc_load_val = 32'd0;
    tick;
    tick;
    reset = 1'b0; pc_load = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        en;
    logic        halt;
    logic [2:0]  cause;
  } vec_t;
  vec_t vt [8];

  // Reference model state (rule level): mode 0 halt, 1 run, 2 step, 3 dump.
  int          m_mode;
  bit          m_skip;
  logic [2:0]  m_cause;
  logic [31:0] m_ret;
  int          m_idx;
  bit          m_bpv [4];
  logic [29:0] m_bpa [4];

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, cyc, n, sl;
    bit rdy, acc, hitbp, brk, stop, en;

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'd0;
    regs[5] = 32'hDEADBEEF;

    vt[0] = '{32'h0000_0100, NOP_I,        1'b0, 1'b1, 3'd3};
    vt[1] = '{32'h0000_0204, NOP_I,        1'b0, 1'b1, 3'd3};
    vt[2] = '{32'h0000_0104, NOP_I,        1'b1, 1'b0, 3'd1};
    vt[3] = '{32'h0000_0300, EBRK,         1'b0, 1'b1, 3'd4};
    vt[4] = '{32'h0000_0100, EBRK,         1'b0, 1'b1, 3'd3};
    vt[5] = '{32'h0000_0200, 32'h00000073, 1'b1, 1'b0, 3'd1};
    vt[6] = '{32'h0000_0103, NOP_I,        1'b0, 1'b1, 3'd3};
    vt[7] = '{32'h0000_0300, 32'h00100074, 1'b1, 1'b0, 3'd1};

    // 1: reset state, RUN, retired counting, host HALT commits.
    do_reset;
    chk("rst_halted", halted, 1);
    chk("rst_cause", halt_cause, 0);
    chk("rst_core_en", core_en, 0);
    chk("rst_retired", retired, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dbg_sel", dbg_sel, 0);
    send_cmd(OP_RUN, 0);
    chk("run_core_en", core_en, 1);
    chk("run_halted", halted, 0);
    repeat (5) tick;
    chk("run_retired5", retired, 5);
    send_cmd(OP_HALT, 0);
    chk("host_halt_cause", halt_cause, 1);
    chk("host_halt_retired", retired, 6);
    chk("host_halt_pc", pc_q, 32'h18);

    // 2: breakpoint at 0x40, then resume executes it once.
    do_reset;
    send_cmd(OP_SETBP, 32'h40);
    send_cmd(OP_RUN, 0);
    wait_halt(40);
    chk("bp_pc", pc_q, 32'h40);
    chk("bp_cause", halt_cause, 3);
    chk("bp_retired", retired, 16);
    chk("bp_core_en", core_en, 0);
    send_cmd(OP_RUN, 0);
    chk("resume_core_en", core_en, 1);
    tick;
    chk("resume_pc", pc_q, 32'h44);
    chk("resume_running", halted, 0);
    send_cmd(OP_HALT, 0);
    chk("resume_halt_pc", pc_q, 32'h48);
    chk("resume_retired", retired, 18);

    // 3: single step from 0x8.
    load_pc(32'h8);
    send_cmd(OP_STEP, 0);
    chk("step_core_en", core_en, 1);
    chk("step_cmd_ready", cmd_ready, 0);
    tick;
    chk("step_halted", halted, 1);
    chk("step_cause", halt_cause, 2);
    chk("step_pc", pc_q, 32'hC);
    chk("step_retired", retired, 19);
    chk("step_core_en_after", core_en, 0);

    // 4: dump with toggling back-pressure.
    send_cmd(OP_DUMP, 0);
    nb = 0; cyc = 0; rdy = 1'b1;
    while (nb < 32 && cyc < 200) begin
      dump_ready = rdy;
      #1;
      if (dump_valid && dump_ready) begin
        chk("dump_idx", dump_idx, nb);
        chk("dump_data", dump_data, regs[nb]);
        if (nb == 5) chk("dump_x5", dump_data, 32'hDEADBEEF);
        nb++;
      end
      chk("dump_cmd_ready", cmd_ready, 0);
      tick;
      cyc++;
      rdy = !rdy;
    end
    dump_ready = 1'b0;
    chk("dump_beats", nb, 32);
    chk("dump_cycles", cyc, 63);
    chk("dump_end_halted", halted, 1);
    chk("dump_end_cause", halt_cause, 2);
    chk("dump_end_sel", dbg_sel, 0);
    chk("dump_end_valid", dump_valid, 0);

    // 5: EBREAK coinciding with bp slot1, then EBREAK alone.
    do_reset;
    ebrk_en = 1'b1; ebrk_addr = 32'h20;
    send_cmd(OP_SETBP, 32'h21);
    send_cmd(OP_RUN, 0);
    wait_halt(20);
    chk("ebp_pc", pc_q, 32'h20);
    chk("ebp_cause", halt_cause, 3);
    chk("ebp_core_en", core_en, 0);
    send_cmd(OP_CLRBP, 32'h1);
    send_cmd(OP_RUN, 0);
    chk("ebp_resume_en", core_en, 1);
    tick;
    chk("ebp_resume_pc", pc_q, 32'h24);
    send_cmd(OP_HALT, 0);
    load_pc(32'h1C);
    send_cmd(OP_RUN, 0);
    wait_halt(10);
    chk("ebrk_pc", pc_q, 32'h20);
    chk("ebrk_cause", halt_cause, 4);
    ebrk_en = 1'b0;

    // Vector table: one checked RUN cycle (skip already cleared) per entry.
    do_reset;
    send_cmd(OP_SETBP, 32'h100);
    send_cmd(OP_SETBP, 32'h205);
    send_cmd(OP_SETBP, 32'h106);
    for (int v = 0; v < 8; v++) begin
      load_pc(32'h1000);
      send_cmd(OP_RUN, 0);
      tick;
      pc_force = 1'b1; pc_force_val = vt[v].pc;
      instr_force = 1'b1; instr_force_val = vt[v].instr;
      #1;
      chk($sformatf("vec%0d_core_en", v), core_en, vt[v].en);
      tick;
      pc_force = 1'b0; instr_force = 1'b0;
      chk($sformatf("vec%0d_halted", v), halted, vt[v].halt);
      if (!halted) send_cmd(OP_HALT, 0);
      chk($sformatf("vec%0d_cause", v), halt_cause, vt[v].cause);
    end

    // 6: reset mid-dump is asynchronous; then host HALT meets a breakpoint.
    do_reset;
    dump_ready = 1'b1;
    send_cmd(OP_DUMP, 0);
    repeat (10) tick;
    chk("abort_sel_before", dbg_sel, 10);
    #2 reset = 1'b1;
    #1;
    chk("abort_dump_valid", dump_valid, 0);
    chk("abort_dbg_sel", dbg_sel, 0);
    chk("abort_halted", halted, 1);
    @(negedge clk);
    reset = 1'b0; dump_ready = 1'b0;
    tick;
    chk("abort_no_resume", dump_valid, 0);
    load_pc(32'h0);
    send_cmd(OP_SETBP, 32'h10);
    send_cmd(OP_RUN, 0);
    n = 0;
    while (PC != 32'h10 && n < 20) begin tick; n++; end
    chk("reach_0x10", PC, 32'h10);
    cmd_valid = 1'b1; cmd_op = OP_HALT; cmd_data = 32'd0;
    #1;
    chk("hbp_core_en", core_en, 0);
    tick;
    cmd_valid = 1'b0; cmd_op = OP_NOP;
    chk("hbp_halted", halted, 1);
    chk("hbp_cause", halt_cause, 3);
    chk("hbp_pc", pc_q, 32'h10);

    // Randomized run against the rule-level model.
    do_reset;
    m_mode = 0; m_skip = 0; m_cause = 3'd0; m_ret = 32'd0; m_idx = 0;
    for (int s = 0; s < 4; s++) begin m_bpv[s] = 0; m_bpa[s] = 30'd0; end
    pc_force = 1'b1; instr_force = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_op    = 3'($urandom_range(0, 6));
      cmd_data  = {22'd0, 8'(8'h10 + $urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      pc_force_val = {22'd0, 8'(8'h10 + $urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      instr_force_val = ($urandom_range(0, 5) == 0) ? EBRK :
                        (($urandom_range(0, 7) == 0) ? 32'h00000073 : NOP_I);
      dump_ready = 1'($urandom_range(0, 1));
      #1;
      acc   = cmd_valid && (m_mode <= 1);
      hitbp = 0;
      for (int s = 0; s < BPN; s++) if (m_bpv[s] && m_bpa[s] == PC[31:2]) hitbp = 1;
      brk   = (Instr == EBRK);
      stop  = (m_mode == 1) && !m_skip && (hitbp || brk);
      en    = (m_mode == 2) || (m_mode == 1 && !stop);
      chk("rnd_core_en", core_en, en);
      chk("rnd_cmd_ready", cmd_ready, (m_mode <= 1));
      chk("rnd_halted", halted, (m_mode == 0));
      chk("rnd_cause", halt_cause, m_cause);
      chk("rnd_dump_valid", dump_valid, (m_mode == 3));
      chk("rnd_dbg_sel", dbg_sel, m_idx);
      chk("rnd_dump_data", dump_data, regs[m_idx]);
      chk("rnd_retired", retired, m_ret);
      tick;
      if (en) m_ret = m_ret + 1;
      sl = int'(cmd_data[1:0]);
      if (acc && cmd_op == OP_SETBP && sl < BPN) begin m_bpv[sl] = 1; m_bpa[sl] = cmd_data[31:2]; end
      if (acc && cmd_op == OP_CLRBP && sl < BPN) m_bpv[sl] = 0;
      case (m_mode)
        0: if (acc) begin
             if (cmd_op == OP_RUN) begin m_mode = 1; m_skip = 1; end
             else if (cmd_op == OP_STEP) m_mode = 2;
             else if (cmd_op == OP_DUMP) begin m_mode = 3; m_idx = 0; end
           end
        1: begin
             m_skip = 0;
             if (stop) begin m_mode = 0; m_cause = hitbp ? 3'd3 : 3'd4; end
             else if (acc && cmd_op == OP_HALT) begin m_mode = 0; m_cause = 3'd1; end
           end
        2: begin m_mode = 0; m_cause = 3'd2; end
        default: if (dump_ready) begin
             if (m_idx == 31) begin m_mode = 0; m_idx = 0; end
             else m_idx = m_idx + 1;
           end
      endcase
    end
    cmd_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
